// File: rtl/archinfo_pkg.sv
// Shared constants and types for the architecture-information register block:
// register offsets, default contents and the decoded register index.
package archinfo_pkg;

  localparam logic [31:0] SYS_OFS = 32'h0000_0000;
  localparam logic [31:0] IDL_OFS = 32'h0000_0004;
  localparam logic [31:0] IDH_OFS = 32'h0000_0008;

  localparam logic [31:0] SYS_RST_DEF = 32'h101F_1010;
  localparam logic [31:0] IDL_VAL_DEF = 32'hFFFF_2022;
  localparam logic [31:0] IDH_VAL_DEF = 32'hFFFF_FFFF;
  localparam int unsigned DEC_MSB_DEF = 11;

  typedef enum logic [1:0] {
    REG_SYS  = 2'd0,
    REG_IDL  = 2'd1,
    REG_IDH  = 2'd2,
    REG_NONE = 2'd3
  } reg_idx_e;

endpackage

// File: rtl/apb4_archinfo_regs_if.sv
// APB4 bus bundle between a master and the architecture-information slave.
// Pure signal grouping; no logic, no timing of its own.
interface apb4_archinfo_regs_if;

  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/archinfo_strb_reg.sv
// 32-bit register with per-byte write strobes and a parameterised reset value.
// Latency: write visible one clk_i edge after we; no backpressure (always accepts).
// Reset is asynchronous and active-high, forcing RST_VAL while rst_i is held.
module archinfo_strb_reg #(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we,
  input  logic [3:0]  strb,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q <= RST_VAL;
    end else if (we) begin
      for (int n = 0; n < 4; n++) begin
        if (strb[n]) begin
          q[8*n +: 8] <= wdata[8*n +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/apb4_archinfo_regs.sv
// APB4 slave exposing SYS (RW, byte strobes) and constant IDL/IDH identification words.
// Latency: zero wait states, read data combinational; SYS write lands on the access edge.
// Backpressure: none, pready is tied high; unmapped or read-only writes flag pslverr.
module apb4_archinfo_regs
  import archinfo_pkg::*;
#(
  parameter logic [31:0] SYS_RST = SYS_RST_DEF,
  parameter logic [31:0] IDL_VAL = IDL_VAL_DEF,
  parameter logic [31:0] IDH_VAL = IDH_VAL_DEF,
  parameter int unsigned DEC_MSB = DEC_MSB_DEF
) (
  input logic                 clk_i,
  input logic                 rst_i,
  apb4_archinfo_regs_if.slave bus
);

  logic [DEC_MSB:2] word;
  reg_idx_e         idx;
  logic             access;
  logic             sys_we;
  logic [31:0]      sys_q;
  logic [31:0]      rd_word;
  logic             unused;

  // Only the word offset within the decoded window matters; base bits and byte lanes alias.
  assign word   = bus.paddr[DEC_MSB:2];
  assign unused = ^{bus.pprot, bus.paddr};

  always_comb begin
    idx = REG_NONE;
    if (word == SYS_OFS[DEC_MSB:2]) begin
      idx = REG_SYS;
    end else if (word == IDL_OFS[DEC_MSB:2]) begin
      idx = REG_IDL;
    end else if (word == IDH_OFS[DEC_MSB:2]) begin
      idx = REG_IDH;
    end
  end

  assign access = bus.psel && bus.penable;
  assign sys_we = access && bus.pwrite && (idx == REG_SYS);

  archinfo_strb_reg #(
    .RST_VAL (SYS_RST)
  ) u_sys (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (sys_we),
    .strb  (bus.pstrb),
    .wdata (bus.pwdata),
    .q     (sys_q)
  );

  always_comb begin
    rd_word = '0;
    case (idx)
      REG_SYS:  rd_word = sys_q;
      REG_IDL:  rd_word = IDL_VAL;
      REG_IDH:  rd_word = IDH_VAL;
      REG_NONE: rd_word = '0;
      default:  rd_word = '0;
    endcase
  end

  assign bus.pready  = 1'b1;
  assign bus.prdata  = (bus.psel && !bus.pwrite) ? rd_word : 32'h0;
  // Error only in the access phase, so setup-phase decode glitches never reach the master.
  assign bus.pslverr = access &&
                       ((idx == REG_NONE) ||
                        (bus.pwrite && ((idx == REG_IDL) || (idx == REG_IDH))));

endmodule

// File: tb/tb_apb4_archinfo_regs.sv
// Directed plus randomized APB4 traffic against apb4_archinfo_regs, checked by a
// behavioural register-map model with immediate assertions.
module tb_apb4_archinfo_regs;

  localparam logic [31:0] SYS_RST_C = 32'h101F_1010;
  localparam logic [31:0] IDL_C     = 32'hFFFF_2022;
  localparam logic [31:0] IDH_C     = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  apb4_archinfo_regs_if bus ();

  apb4_archinfo_regs dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sys_m;
  logic [31:0] last_rd;
  logic [31:0] last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word offset inside the 4 KiB decode window, byte-lane bits dropped.
  function automatic int unsigned ofs(input logic [31:0] a);
    return (a % 4096) - (a % 4);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int unsigned o;
    o = ofs(a);
    if (o == 0) return sys_m;
    if (o == 4) return IDL_C;
    if (o == 8) return IDH_C;
    return 32'h0;
  endfunction

  function automatic logic exp_err(input logic wr, input logic [31:0] a);
    int unsigned o;
    o = ofs(a);
    return !(o == 0 || o == 4 || o == 8) || (wr && o != 0);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Starts #1 after a rising edge, ends #1 after the access-phase edge with the bus still selected.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    logic [31:0] er;
    logic        ee;
    er = wr ? 32'h0 : exp_rd(a);
    ee = exp_err(wr, a);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = a;
    bus.pwdata  = d;
    bus.pstrb   = s;
    bus.pprot   = 3'($urandom_range(0, 7));
    #1;
    check("setup_pslverr", {31'b0, bus.pslverr}, 32'h0);
    check("setup_prdata", bus.prdata, er);
    @(posedge clk);
    #1;
    bus.penable = 1'b1;
    #1;
    check("access_pready", {31'b0, bus.pready}, 32'h1);
    check("access_pslverr", {31'b0, bus.pslverr}, {31'b0, ee});
    check("access_prdata", bus.prdata, er);
    last_rd  = bus.prdata;
    last_err = {31'b0, bus.pslverr};
    @(posedge clk);
    #1;
    if (wr && ofs(a) == 0) sys_m = merge(sys_m, d, s);
  endtask

  task automatic idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    @(posedge clk);
    #1;
    check("idle_prdata", bus.prdata, 32'h0);
    check("idle_pslverr", {31'b0, bus.pslverr}, 32'h0);
  endtask

  initial begin
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] addr;
    logic [31:0] offs_tab [6];

    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 32'h0;
    bus.pwdata  = 32'h0;
    bus.pstrb   = 4'h0;
    bus.pprot   = 3'h0;
    sys_m       = SYS_RST_C;

    repeat (40) @(posedge clk);
    #1;
    check("rst_pready", {31'b0, bus.pready}, 32'h1);
    check("rst_pslverr", {31'b0, bus.pslverr}, 32'h0);
    check("rst_prdata", bus.prdata, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Boot-time identification reads through a high base address.
    xfer(1'b0, 32'hFFFF_0000, 32'h0, 4'h0);
    check("rd_sys_rst", last_rd, 32'h101F_1010);
    xfer(1'b0, 32'hFFFF_0004, 32'h0, 4'h0);
    check("rd_idl", last_rd, 32'hFFFF_2022);
    xfer(1'b0, 32'hFFFF_0008, 32'h0, 4'h0);
    check("rd_idh", last_rd, 32'hFFFF_FFFF);
    idle();

    xfer(1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF);
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    check("sys_full_wr", last_rd, 32'hDEAD_BEEF);
    xfer(1'b1, 32'h0, 32'h1234_5678, 4'h5);
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    check("sys_strb_wr", last_rd, 32'hDE34_BE78);
    xfer(1'b1, 32'h0, 32'h0000_0000, 4'h0);
    check("sys_strb0_err", last_err, 32'h0);
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    check("sys_strb0_keep", last_rd, 32'hDE34_BE78);
    idle();

    xfer(1'b1, 32'h4, 32'h0, 4'hF);
    check("wr_idl_err", last_err, 32'h1);
    xfer(1'b1, 32'h8, 32'h0, 4'hF);
    check("wr_idh_err", last_err, 32'h1);
    xfer(1'b0, 32'h4, 32'h0, 4'h0);
    check("idl_kept", last_rd, 32'hFFFF_2022);
    xfer(1'b0, 32'h8, 32'h0, 4'h0);
    check("idh_kept", last_rd, 32'hFFFF_FFFF);

    xfer(1'b0, 32'hC, 32'h0, 4'h0);
    check("rd_0c_err", last_err, 32'h1);
    check("rd_0c_data", last_rd, 32'h0);
    xfer(1'b0, 32'h100, 32'h0, 4'h0);
    check("rd_100_err", last_err, 32'h1);
    xfer(1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF);
    check("wr_0c_err", last_err, 32'h1);
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    check("sys_after_0c", last_rd, 32'hDE34_BE78);
    idle();

    // Asynchronous reset in the middle of a SYS write access.
    xfer(1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF);
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    check("sys_a5", last_rd, 32'hA5A5_A5A5);
    bus.pwrite  = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = 32'h0;
    bus.pwdata  = 32'h0BAD_F00D;
    bus.pstrb   = 4'hF;
    @(posedge clk);
    #1;
    bus.penable = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    bus.pwrite = 1'b0;
    #2;
    check("rst_async_sys", bus.prdata, 32'h101F_1010);
    check("rst_async_err", {31'b0, bus.pslverr}, 32'h0);
    sys_m = SYS_RST_C;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_sys", bus.prdata, 32'h101F_1010);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    check("sys_after_rst", last_rd, 32'h101F_1010);

    // Back-to-back write then read with no idle cycle.
    xfer(1'b1, 32'h0, 32'h0000_00FF, 4'hF);
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    check("b2b_rd", last_rd, 32'h0000_00FF);
    idle();

    offs_tab[0] = 32'h0;
    offs_tab[1] = 32'h4;
    offs_tab[2] = 32'h8;
    offs_tab[3] = 32'hC;
    offs_tab[4] = 32'h100;
    offs_tab[5] = 32'hFFC;
    for (int i = 0; i < 80; i++) begin
      base = $urandom;
      if ($urandom_range(0, 4) == 0) off = 32'($urandom_range(0, 4095));
      else off = offs_tab[$urandom_range(0, 5)];
      addr = (base & 32'hFFFF_F000) | (off & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
      xfer(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    check("final_sys", last_rd, sys_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb4_archinfo_regs.md
Name: apb4_archinfo_regs

Overview:
APB4 slave exposing three 32-bit architecture-information registers: SYS, IDL and IDH. SYS is software-writable and holds system configuration/identification. IDL and IDH are constant read-only identification words. The block sits on the peripheral APB4 bus, and software reads it at boot to identify the SoC.

Parameters:
SYS_RST, 32'h101F_1010, reset value of SYS
IDL_VAL, 32'hFFFF_2022, constant returned by IDL
IDH_VAL, 32'hFFFF_FFFF, constant returned by IDH
DEC_MSB, 11, top paddr bit decoded; higher bits are ignored

Ports:
clk_i  in  1  bus clock; all state on rising edge
rst_i  in  1  asynchronous, active-high reset
paddr_i  in  32  APB4 address
pprot_i  in  3  protection; ignored
psel_i  in  1  slave select
penable_i  in  1  access phase
pwrite_i  in  1  1 = write
pwdata_i  in  32  write data
pstrb_i  in  4  byte write strobes
pready_o  out  1  ready
prdata_o  out  32  read data
pslverr_o  out  1  transfer error

Behaviour:
- Clocking and reset: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Address decode: uses paddr_i[DEC_MSB:2].
  - 0x0 = SYS (RW)
  - 0x4 = IDL (RO)
  - 0x8 = IDH (RO)
  - Every other offset is unmapped.
  - paddr_i[1:0] are ignored.
  - Base address bits above DEC_MSB are ignored; for example, 0xFFFF_0004 hits IDL.
- pready_o is constant 1: zero wait states, so every transfer completes in the cycle where psel_i and penable_i are both high.
- Read data:
  - prdata_o is combinational from the decoded register whenever psel_i=1 and pwrite_i=0; it is 0 otherwise.
  - Unmapped reads return 0.
- Write to SYS:
  - Occurs on the rising clk_i edge when psel_i, penable_i, pwrite_i and the SYS decode are all 1.
  - Byte n is updated from pwdata_i[8n+7:8n] only when pstrb_i[n]=1.
  - pstrb_i=0 leaves SYS unchanged; this is not an error.
- Writes to IDL, IDH or unmapped offsets have no state effect.
- pslverr_o:
  - Combinational.
  - Asserted only when psel_i and penable_i are both 1 and either the offset is unmapped or the access is a write to IDL/IDH.
  - 0 at all other times, including the setup phase.
- Reset:
  - While rst_i=1, SYS = SYS_RST, independent of clk_i.
  - If reset is asserted mid-transfer, any write in progress is discarded.
  - Outputs hold no other state; after reset, pready_o=1, pslverr_o=0 and prdata_o=0 until selected.
- Back-to-back transfers (setup phase immediately following an access) are supported with no idle cycle.
- A read in the cycle after a SYS write returns the new value.
- pprot_i has no effect.

Decomposition:
- Package archinfo_pkg:
  - Offset constants SYS_OFS=0x0, IDL_OFS=0x4, IDH_OFS=0x8.
  - Default values SYS_RST/IDL_VAL/IDH_VAL.
  - Register-index enum.
- One natural sub-module: archinfo_strb_reg, a 32-bit register with byte strobes, asynchronous active-high reset and a parameterised reset value, used for SYS.
- Decode and error logic stay in the top module.
- The APB4 interface bundle and master bus-functional model are the existing shared verification components; the RTL ports above map 1:1 onto the interface signals.

Test Plan:
- Hold rst_i high for 40 cycles, then release; read 0xFFFF_0000, 0xFFFF_0004, 0xFFFF_0008 -> 0x101F_1010, 0xFFFF_2022, 0xFFFF_FFFF, each with pslverr_o=0 and pready_o=1.
- Write SYS with 0xDEAD_BEEF and pstrb=0xF, then read back -> 0xDEAD_BEEF. Then write 0x1234_5678 with pstrb=0x5 -> 0xDE34_BE78.
- Write 0 to IDL (0x4) and to IDH (0x8) -> pslverr_o=1 during the access phase; readback is still 0xFFFF_2022 and 0xFFFF_FFFF.
- Read offsets 0xC and 0x100 -> prdata_o=0 with pslverr_o=1. Write 0xFFFF_FFFF to 0xC -> pslverr_o=1 and SYS is unchanged.
- Write SYS=0xA5A5_A5A5, then assert rst_i asynchronously between clock edges during a later SYS write access -> SYS returns to 0x101F_1010 immediately and the pending write is lost; after release, a read returns 0x101F_1010.
- Perform a back-to-back write of SYS=0x0000_00FF followed immediately by a read of SYS with no idle cycle -> read returns 0x0000_00FF.
